// File: rtl/wb_register_file_pkg.sv
// Shared write-back / register-file constants, also used by ID-stage and hazard logic.
package wb_register_file_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int CNT_W    = 32;
   localparam int REG_ZERO = 0;

   // True when the address targets the hardwired zero register.
   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
      return addr == ADDR_W'(REG_ZERO);
   endfunction
endpackage

// File: rtl/wb_register_file_wb_mux.sv
// 2:1 write-back source select (load data vs ALU result); purely combinational.
module wb_mux #(
   parameter int W = 32
) (
   input  logic         sel_mem_i,
   input  logic [W-1:0] alu_data_i,
   input  logic [W-1:0] mem_data_i,
   output logic [W-1:0] wb_data_o
);
   assign wb_data_o = sel_mem_i ? mem_data_i : alu_data_i;
endmodule

// File: rtl/wb_register_file.sv
// Write-back stage plus 32xDATA_W register file with write-through read bypass.
// Reads are combinational; one commit per cycle when enabled; counts committed writes.
module wb_register_file
   import wb_register_file_pkg::*;
#(
   parameter int DATA_W = wb_register_file_pkg::DATA_W,
   parameter int ADDR_W = wb_register_file_pkg::ADDR_W,
   parameter int CNT_W  = wb_register_file_pkg::CNT_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              RegWrite_i,
   input  logic              MemReg_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] alu_data_i,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic [ADDR_W-1:0] rs1_addr_i,
   input  logic [ADDR_W-1:0] rs2_addr_i,
   output logic [DATA_W-1:0] rs1_data_o,
   output logic [DATA_W-1:0] rs2_data_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              wb_en_o,
   output logic [CNT_W-1:0]  commit_cnt_o
);
   localparam int NREGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [CNT_W-1:0]  r_commit_cnt;
   logic [DATA_W-1:0] w_wb_data;
   logic              w_wb_en;

   wb_mux #(.W(DATA_W)) u_wb_mux (
      .sel_mem_i  (MemReg_i),
      .alu_data_i (alu_data_i),
      .mem_data_i (mem_data_i),
      .wb_data_o  (w_wb_data)
   );

   // Writes to x0 are squashed here so they neither commit, bypass, nor count.
   assign w_wb_en = start_i & RegWrite_i & (rd_addr_i != ZERO_ADDR) & ~rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_commit_cnt <= '0;
      end else if (w_wb_en) begin
         r_regs[rd_addr_i] <= w_wb_data;
         r_commit_cnt      <= r_commit_cnt + 1'b1;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      if (addr == ZERO_ADDR)                return '0;
      else if (w_wb_en && rd_addr_i == addr) return w_wb_data;
      else                                   return r_regs[addr];
   endfunction

   always_comb begin
      rs1_data_o = read_port(rs1_addr_i);
      rs2_data_o = read_port(rs2_addr_i);
   end

   assign wb_data_o    = w_wb_data;
   assign wb_en_o      = w_wb_en;
   assign commit_cnt_o = r_commit_cnt;
endmodule

// File: tb/tb_wb_register_file.sv
// Directed-vector bench: driver queues expected outputs, negedge monitor pops and compares.
module tb_wb_register_file;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, start, we, memreg;
   logic [AW-1:0] rd, rs1, rs2;
   logic [DW-1:0] alu, mem;
   logic [DW-1:0] rs1_d, rs2_d, wb_d;
   logic          wb_en;
   logic [CW-1:0] cnt;

   typedef struct {
      string         name;
      logic [DW-1:0] rs1;
      logic [DW-1:0] rs2;
      logic [DW-1:0] wbd;
      logic          en;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   wb_register_file #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .RegWrite_i(we), .MemReg_i(memreg),
      .rd_addr_i(rd), .alu_data_i(alu), .mem_data_i(mem),
      .rs1_addr_i(rs1), .rs2_addr_i(rs2),
      .rs1_data_o(rs1_d), .rs2_data_o(rs2_d), .wb_data_o(wb_d),
      .wb_en_o(wb_en), .commit_cnt_o(cnt)
   );

   task automatic cmp(input string nm, input string fld, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, exp);
      end
   endtask

   // Monitor: one expectation is presented per cycle; compare mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "rs1",  rs1_d, e.rs1);
            cmp(e.name, "rs2",  rs2_d, e.rs2);
            cmp(e.name, "wbd",  wb_d,  e.wbd);
            cmp(e.name, "wben", DW'(wb_en), DW'(e.en));
            cmp(e.name, "cnt",  DW'(cnt),   DW'(e.cnt));
         end
      end
   end

   // Driver: apply inputs just after the edge and queue the hand-computed response.
   task automatic vec(input string nm, input logic r, input logic s, input logic w, input logic m,
                      input logic [AW-1:0] d, input logic [DW-1:0] a, input logic [DW-1:0] md,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [DW-1:0] x1, input logic [DW-1:0] x2, input logic [DW-1:0] xw,
                      input logic xe, input logic [CW-1:0] xc);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; start = s; we = w; memreg = m; rd = d; alu = a; mem = md; rs1 = a1; rs2 = a2;
      e.name = nm; e.rs1 = x1; e.rs2 = x2; e.wbd = xw; e.en = xe; e.cnt = xc;
      q.push_back(e);
   endtask

   initial begin
      int budget;
      rst = 1'b1; start = 1'b0; we = 1'b0; memreg = 1'b0;
      rd = '0; alu = '0; mem = '0; rs1 = '0; rs2 = '0;
      repeat (2) @(posedge clk);

      //   name         rst s we ms rd  alu           mem           rs1 rs2 exp_rs1       exp_rs2       exp_wbd       en cnt
      vec("reset",      1, 1, 1, 0, 5,  32'h1234,     32'h0,        5,  31, 32'h0,        32'h0,        32'h1234,     0, 0);
      vec("bypass",     0, 1, 1, 0, 5,  32'h1234,     32'h0,        5,  31, 32'h1234,     32'h0,        32'h1234,     1, 0);
      vec("stored",     0, 1, 0, 0, 0,  32'h0,        32'h0,        5,  5,  32'h1234,     32'h1234,     32'h0,        0, 1);
      vec("x0_write",   0, 1, 1, 1, 0,  32'h0,        32'hDEADBEEF, 0,  0,  32'h0,        32'h0,        32'hDEADBEEF, 0, 1);
      vec("stall",      0, 0, 1, 0, 7,  32'h55,       32'h0,        7,  5,  32'h0,        32'h1234,     32'h55,       0, 1);
      vec("stall_hold", 0, 1, 0, 0, 0,  32'h0,        32'h0,        7,  0,  32'h0,        32'h0,        32'h0,        0, 1);
      vec("dual_byp",   0, 1, 1, 1, 3,  32'h0,        32'hCAFEF00D, 3,  3,  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1);
      vec("dual_rd",    0, 1, 0, 0, 0,  32'h0,        32'h0,        3,  5,  32'hCAFEF00D, 32'h1234,     32'h0,        0, 2);
      vec("rst_write",  1, 1, 1, 0, 9,  32'hA5A5A5A5, 32'h0,        9,  3,  32'h0,        32'hCAFEF00D, 32'hA5A5A5A5, 0, 2);
      vec("post_rst",   0, 1, 0, 0, 0,  32'h0,        32'h0,        9,  3,  32'h0,        32'h0,        32'h0,        0, 0);
      vec("wr_r9",      0, 1, 1, 0, 9,  32'h1,        32'h0,        9,  0,  32'h1,        32'h0,        32'h1,        1, 0);
      vec("rd_r9",      0, 1, 0, 0, 0,  32'h0,        32'h0,        9,  9,  32'h1,        32'h1,        32'h0,        0, 1);

      // Fifteen commits take the 4-bit counter from 1 through 15 and wrap to 0.
      for (int i = 0; i < 15; i++) begin
         vec("wrap_run", 0, 1, 1, 0, AW'(10 + i), DW'(32'h100 + i), 32'h0,
             AW'(10 + i), 9, DW'(32'h100 + i), 32'h1, DW'(32'h100 + i), 1, CW'(i + 1));
      end
      vec("wrap_zero",  0, 1, 0, 0, 0,  32'h0,        32'h0,        24, 10, 32'h10E,      32'h100,      32'h0,        0, 0);

      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_register_file.md
# wb_register_file

Write-back stage and integer register file for the 5-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result or load data), commits it to a 32x32 register file, and serves the two ID-stage read ports with same-cycle write-through bypass. It also keeps a free-running count of committed register writes for debug and retirement checks.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width (2^ADDR_W registers)
- CNT_W, 32, width of the write-commit counter

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  pipeline run enable; 0 blocks all commits and counter updates
- RegWrite_i  in  1  write-back request from MEM/WB
- MemReg_i  in  1  write-back source select: 1 = mem_data_i, 0 = alu_data_i
- rd_addr_i  in  ADDR_W  destination register
- alu_data_i  in  DATA_W  ALU result from MEM/WB
- mem_data_i  in  DATA_W  load data from MEM/WB
- rs1_addr_i  in  ADDR_W  ID-stage read address 1
- rs2_addr_i  in  ADDR_W  ID-stage read address 2
- rs1_data_o  out  DATA_W  read data 1 (combinational)
- rs2_data_o  out  DATA_W  read data 2 (combinational)
- wb_data_o  out  DATA_W  selected write-back value (combinational, for EX forwarding)
- wb_en_o  out  1  write commits at next edge (combinational)
- commit_cnt_o  out  CNT_W  number of committed writes since reset

## Operation
- wb_data_o = MemReg_i ? mem_data_i : alu_data_i, independent of RegWrite_i.
- wb_en_o = start_i & RegWrite_i & (rd_addr_i != 0) & ~rst_i.
- Commit: at rising edge with wb_en_o=1, regs[rd_addr_i] <= wb_data_o; commit_cnt_o increments by 1.
- x0 hardwired: never written; reads of address 0 return 0 always, including under bypass conditions.
- Read path: rsN_data_o = 0 if rsN_addr_i==0; else wb_data_o if wb_en_o and rd_addr_i==rsN_addr_i; else regs[rsN_addr_i].
- Both read ports independent; both may bypass in the same cycle.
- RegWrite_i=1 with rd_addr_i=0: no write, no bypass, counter unchanged.
- start_i=0: register contents and counter hold; reads remain live from stored contents, no bypass.
- commit_cnt_o wraps from 2^CNT_W-1 to 0 silently.
- Reset (rst_i=1 at an edge): all registers cleared to 0, commit_cnt_o to 0; reset overrides any concurrent commit. While rst_i=1, wb_en_o=0 so no bypass; reads return stored values (0 after first reset edge).

## Timing
- Write latency: 1 cycle; value visible in storage after the commit edge, visible on read ports in the same cycle via bypass.
- Read latency: 0 (combinational from addresses, stored state and WB inputs).
- commit_cnt_o updates on the same edge as the write.
- Reset values: all registers 0, commit_cnt_o 0; rs1_data_o/rs2_data_o 0 after reset; wb_data_o/wb_en_o follow inputs (wb_en_o forced 0 during reset).
- Reset mid-stream: write presented in the reset cycle is dropped; first commit possible on the edge after rst_i deasserts.

## Structure
- Shared package: DATA_W, ADDR_W defaults, REG_ZERO address constant, shared with ID-stage and hazard logic.
- One sub-module: wb_mux (2:1 write-back source select), reused by the EX forwarding path.
- Storage as a flat register array; no memory macro.

## Test plan
- Reset, then read rs1=5, rs2=31 -> both 0; commit_cnt_o=0.
- RegWrite=1, MemReg=0, rd=5, alu=0x0000_1234, start=1; same cycle rs1=5 -> rs1_data_o=0x1234 (bypass); next cycle with RegWrite=0 -> still 0x1234; commit_cnt_o=1.
- RegWrite=1, MemReg=1, rd=0, mem=0xDEAD_BEEF, rs1=rs2=0 -> reads 0, wb_en_o=0, wb_data_o=0xDEADBEEF, commit_cnt_o unchanged.
- start_i=0, RegWrite=1, rd=7, alu=0x55 -> no bypass, regs[7] unchanged after edge, counter unchanged.
- Write rd=9 value 0xA5A5_A5A5 with rst_i=1 in same cycle -> regs[9]=0, counter 0; after deassert, write 0x1 to rd=9 -> reads 0x1.
- Preload commit_cnt to all-ones (CNT_W=4 build), one commit -> commit_cnt_o=0.
